axi_wr_txn_scheduler: RTL and testbench

- Control-only scheduler for the cache subsystem's shared AXI write path.
- Round-robin arbitrates AW requests from three requesters: 0 = icache, 1 = bypass, 2 = dcache.
- Records grant order so W beats follow AW order.
- Tracks per-requester outstanding writes until the B response and routes B by ID.
- Payload muxing stays outside; this block only drives selects and valid/ready.

---
 rtl/axi_wr_txn_scheduler.sv | 168 ++++++++++++++++
 tb/tb_axi_wr_txn_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_txn_scheduler.sv
// AXI write-path scheduler: round-robin AW grant, W ordering queue, B-based outstanding tracking.
// Optional AW stall counter is built when WR_SCHED_PERF_CNT_EN is defined.
module axi_wr_txn_scheduler #(
  parameter int MaxOutstanding = 4,
  parameter int OrderDepth     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  req_aw_valid_i,
  output logic [2:0]  req_aw_ready_o,
  output logic        aw_valid_o,
  input  logic        aw_ready_i,
  output logic [1:0]  aw_sel_o,
  input  logic [2:0]  req_w_valid_i,
  input  logic [2:0]  req_w_last_i,
  output logic [2:0]  req_w_ready_o,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  output logic [1:0]  w_sel_o,
  input  logic        b_valid_i,
  input  logic [3:0]  b_id_i,
  output logic [1:0]  b_sel_o,
  output logic        idle_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  localparam int PW = $clog2(OrderDepth);

  typedef enum logic {ST_ARB, ST_HOLD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  aw_sel_q, aw_sel_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  cnt_q [3];
  logic [3:0]  cnt_d [3];
  logic        err_q, err_d;
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]  order_mem [OrderDepth];

  logic        q_empty, q_full, push, pop, found;
  logic [1:0]  head, cand;
  logic [2:0]  sum;
  logic [2:0]  elig;

  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head    = order_mem[rd_ptr_q[PW-1:0]];

  for (genvar gi = 0; gi < 3; gi++) begin : g_elig
    assign elig[gi] = req_aw_valid_i[gi] && (cnt_q[gi] < 4'(MaxOutstanding)) && !q_full;
  end

  // AW arbitration: one ARB cycle to pick, then HOLD the select until the handshake.
  always_comb begin
    state_d        = state_q;
    aw_sel_d       = aw_sel_q;
    rr_ptr_d       = rr_ptr_q;
    aw_valid_o     = 1'b0;
    req_aw_ready_o = '0;
    push           = 1'b0;
    found          = 1'b0;
    sum            = '0;
    cand           = '0;
    case (state_q)
      ST_ARB: begin
        for (int k = 0; k < 3; k++) begin
          sum  = {1'b0, rr_ptr_q} + 3'(k);
          cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
          if (!found && elig[cand]) begin
            found    = 1'b1;
            aw_sel_d = cand;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        aw_valid_o               = req_aw_valid_i[aw_sel_q];
        req_aw_ready_o[aw_sel_q] = aw_ready_i;
        if (aw_valid_o && aw_ready_i) begin
          push     = 1'b1;
          rr_ptr_d = (aw_sel_q == 2'd2) ? 2'd0 : aw_sel_q + 2'd1;
          state_d  = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // W beats follow the queued AW grant order; the head entry leaves on its last beat.
  always_comb begin
    req_w_ready_o = '0;
    w_valid_o     = !q_empty && req_w_valid_i[head];
    w_sel_o       = q_empty ? 2'd0 : head;
    if (!q_empty) req_w_ready_o[head] = w_ready_i;
    pop      = w_valid_o && w_ready_i && req_w_last_i[head];
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
  end

  always_comb begin
    if (b_id_i == 4'b1100)        b_sel_o = 2'd2;
    else if (b_id_i[3:2] == 2'b10) b_sel_o = 2'd1;
    else                           b_sel_o = 2'd0;
  end

  // A B with nothing outstanding leaves the counter at zero and flags the error.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((push && aw_sel_q == 2'(i)) && !(b_valid_i && b_sel_o == 2'(i))) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (!(push && aw_sel_q == 2'(i)) && (b_valid_i && b_sel_o == 2'(i))) begin
        if (cnt_q[i] == 4'd0) err_d = 1'b1;
        else                  cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_ARB;
      aw_sel_q <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      aw_sel_q <= aw_sel_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) order_mem[wr_ptr_q[PW-1:0]] <= aw_sel_q;
  end

  assign aw_sel_o = aw_sel_q;
  assign err_o    = err_q;
  assign idle_o   = q_empty && (cnt_q[0] == 4'd0) && (cnt_q[1] == 4'd0) && (cnt_q[2] == 4'd0);

`ifdef WR_SCHED_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (aw_valid_o && !aw_ready_i && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_wr_txn_scheduler.sv
// Directed bench for axi_wr_txn_scheduler: arbitration, outstanding limit, W ordering, B routing, error, stall count.
module tb_axi_wr_txn_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  req_aw_valid_i, req_aw_ready_o;
  logic        aw_valid_o, aw_ready_i;
  logic [1:0]  aw_sel_o;
  logic [2:0]  req_w_valid_i, req_w_last_i, req_w_ready_o;
  logic        w_valid_o, w_ready_i;
  logic [1:0]  w_sel_o;
  logic        b_valid_i;
  logic [3:0]  b_id_i;
  logic [1:0]  b_sel_o;
  logic        idle_o, err_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  axi_wr_txn_scheduler #(.MaxOutstanding(4), .OrderDepth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_aw_valid_i(req_aw_valid_i), .req_aw_ready_o(req_aw_ready_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_sel_o(aw_sel_o),
    .req_w_valid_i(req_w_valid_i), .req_w_last_i(req_w_last_i), .req_w_ready_o(req_w_ready_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_sel_o(w_sel_o),
    .b_valid_i(b_valid_i), .b_id_i(b_id_i), .b_sel_o(b_sel_o),
    .idle_o(idle_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_aw_valid_i = '0; aw_ready_i = 1'b0;
    req_w_valid_i  = '0; req_w_last_i = '0; w_ready_i = 1'b0;
    b_valid_i      = 1'b0; b_id_i = '0;
    rst_i          = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL reset_aw_valid got %b exp 0", aw_valid_o); end
    checks++; if (w_valid_o !== 1'b0) begin errors++; $display("FAIL reset_w_valid got %b exp 0", w_valid_o); end
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
    checks++; if ({aw_sel_o, w_sel_o, b_sel_o} !== 6'd0) begin errors++; $display("FAIL reset_sels got %b exp 0", {aw_sel_o, w_sel_o, b_sel_o}); end
    checks++; if ({req_aw_ready_o, req_w_ready_o} !== 6'd0) begin errors++; $display("FAIL reset_readies got %b exp 0", {req_aw_ready_o, req_w_ready_o}); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt_o); end
    $display("txn reset done");
  endtask

  // Requesters 1 and 2 alternate; four grants fill the queue and arbitration stops.
  task automatic test_rr_alternate();
    logic [1:0] exp;
    do_reset();
    req_aw_valid_i = 3'b110; aw_ready_i = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp = 2'(1 + (g % 2));
      checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL rr_arb_valid grant %0d got %b exp 0", g, aw_valid_o); end
      tick();
      checks++; if (aw_valid_o !== 1'b1 || aw_sel_o !== exp) begin errors++; $display("FAIL rr_grant %0d got valid %b sel %0d exp valid 1 sel %0d", g, aw_valid_o, aw_sel_o, exp); end
      checks++; if (req_aw_ready_o !== (3'b001 << exp)) begin errors++; $display("FAIL rr_ready %0d got %b exp %b", g, req_aw_ready_o, 3'b001 << exp); end
      $display("txn aw grant %0d sel %0d", g, aw_sel_o);
      tick();
    end
    repeat (2) begin
      checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL rr_full_block got %b exp 0", aw_valid_o); end
      tick();
    end
    checks++; if (w_sel_o !== 2'd1 || idle_o !== 1'b0) begin errors++; $display("FAIL rr_queue_head got sel %0d idle %b exp sel 1 idle 0", w_sel_o, idle_o); end
  endtask

  // All three request; queue drained each cycle, so order wraps 0,1,2,0.
  task automatic test_rr_wrap();
    logic [1:0] exp;
    do_reset();
    req_aw_valid_i = 3'b111; aw_ready_i = 1'b1;
    req_w_valid_i = 3'b111; req_w_last_i = 3'b111; w_ready_i = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp = 2'(g % 3);
      tick();
      checks++; if (aw_valid_o !== 1'b1 || aw_sel_o !== exp) begin errors++; $display("FAIL wrap_grant %0d got valid %b sel %0d exp sel %0d", g, aw_valid_o, aw_sel_o, exp); end
      $display("txn aw wrap grant %0d sel %0d", g, aw_sel_o);
      tick();
    end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    req_aw_valid_i = 3'b100; aw_ready_i = 1'b1;
    req_w_valid_i = 3'b100; req_w_last_i = 3'b100; w_ready_i = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      tick();
      checks++; if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd2) begin errors++; $display("FAIL max_grant %0d got valid %b sel %0d exp valid 1 sel 2", g, aw_valid_o, aw_sel_o); end
      tick();
    end
    repeat (3) begin
      checks++; if (aw_valid_o !== 1'b0 || req_aw_ready_o !== 3'b000) begin errors++; $display("FAIL max_block got valid %b ready %b exp 0 000", aw_valid_o, req_aw_ready_o); end
      tick();
    end
    b_valid_i = 1'b1; b_id_i = 4'b1100;
    #1;
    checks++; if (b_sel_o !== 2'd2 || aw_valid_o !== 1'b0) begin errors++; $display("FAIL max_b got bsel %0d valid %b exp 2 0", b_sel_o, aw_valid_o); end
    tick();
    b_valid_i = 1'b0; b_id_i = '0;
    #1;
    checks++; if (aw_valid_o !== 1'b0) begin errors++; $display("FAIL max_resume_arb got %b exp 0", aw_valid_o); end
    tick();
    checks++; if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd2) begin errors++; $display("FAIL max_resume got valid %b sel %0d exp 1 2", aw_valid_o, aw_sel_o); end
    $display("txn aw resumed after B sel %0d", aw_sel_o);
  endtask

  task automatic test_w_order();
    do_reset();
    req_aw_valid_i = 3'b010; aw_ready_i = 1'b1;
    req_w_valid_i = 3'b100; req_w_last_i = 3'b100; w_ready_i = 1'b1;
    #1;
    checks++; if (w_valid_o !== 1'b0 || w_sel_o !== 2'd0 || req_w_ready_o !== 3'b000) begin errors++; $display("FAIL w_early got valid %b sel %0d ready %b exp 0 0 000", w_valid_o, w_sel_o, req_w_ready_o); end
    tick();
    checks++; if (w_valid_o !== 1'b0 || req_w_ready_o !== 3'b000) begin errors++; $display("FAIL w_no_fallthrough got valid %b ready %b exp 0 000", w_valid_o, req_w_ready_o); end
    tick();
    req_aw_valid_i = 3'b100;
    #1;
    checks++; if (w_sel_o !== 2'd1 || w_valid_o !== 1'b0 || req_w_ready_o !== 3'b010) begin errors++; $display("FAIL w_head1 got sel %0d valid %b ready %b exp 1 0 010", w_sel_o, w_valid_o, req_w_ready_o); end
    tick();
    checks++; if (aw_sel_o !== 2'd2 || aw_valid_o !== 1'b1) begin errors++; $display("FAIL w_aw2 got sel %0d valid %b exp 2 1", aw_sel_o, aw_valid_o); end
    req_w_valid_i = 3'b110; req_w_last_i = 3'b100;
    #1;
    checks++; if (w_valid_o !== 1'b1 || w_sel_o !== 2'd1) begin errors++; $display("FAIL w_beat1 got valid %b sel %0d exp 1 1", w_valid_o, w_sel_o); end
    $display("txn w beat 1 sel %0d", w_sel_o);
    tick();
    req_aw_valid_i = 3'b000; req_w_last_i = 3'b110;
    #1;
    checks++; if (w_valid_o !== 1'b1 || w_sel_o !== 2'd1 || req_w_ready_o !== 3'b010) begin errors++; $display("FAIL w_beat2 got valid %b sel %0d ready %b exp 1 1 010", w_valid_o, w_sel_o, req_w_ready_o); end
    $display("txn w beat 2 last sel %0d", w_sel_o);
    tick();
    req_w_valid_i = 3'b100;
    #1;
    checks++; if (w_valid_o !== 1'b1 || w_sel_o !== 2'd2 || req_w_ready_o !== 3'b100) begin errors++; $display("FAIL w_req2 got valid %b sel %0d ready %b exp 1 2 100", w_valid_o, w_sel_o, req_w_ready_o); end
    $display("txn w beat last sel %0d", w_sel_o);
    tick();
    req_w_valid_i = 3'b000;
    #1;
    checks++; if (w_valid_o !== 1'b0 || w_sel_o !== 2'd0 || idle_o !== 1'b0) begin errors++; $display("FAIL w_empty got valid %b sel %0d idle %b exp 0 0 0", w_valid_o, w_sel_o, idle_o); end
    b_valid_i = 1'b1; b_id_i = 4'b1100;
    #1;
    checks++; if (b_sel_o !== 2'd2) begin errors++; $display("FAIL b_dec_1100 got %0d exp 2", b_sel_o); end
    tick();
    b_id_i = 4'b1011;
    #1;
    checks++; if (b_sel_o !== 2'd1) begin errors++; $display("FAIL b_dec_1011 got %0d exp 1", b_sel_o); end
    tick();
    b_valid_i = 1'b0; b_id_i = 4'b0111;
    #1;
    checks++; if (b_sel_o !== 2'd0) begin errors++; $display("FAIL b_dec_0111 got %0d exp 0", b_sel_o); end
    b_id_i = 4'b1101;
    #1;
    checks++; if (b_sel_o !== 2'd0) begin errors++; $display("FAIL b_dec_1101 got %0d exp 0", b_sel_o); end
    checks++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL b_idle got idle %b err %b exp 1 0", idle_o, err_o); end
    $display("txn b responses done idle %b", idle_o);
  endtask

  task automatic test_err();
    do_reset();
    b_valid_i = 1'b1; b_id_i = 4'b1001;
    #1;
    checks++; if (b_sel_o !== 2'd1) begin errors++; $display("FAIL err_bsel got %0d exp 1", b_sel_o); end
    tick();
    b_valid_i = 1'b0; b_id_i = '0;
    #1;
    checks++; if (err_o !== 1'b1 || idle_o !== 1'b1) begin errors++; $display("FAIL err_set got err %b idle %b exp 1 1", err_o, idle_o); end
    tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
    req_aw_valid_i = 3'b010; aw_ready_i = 1'b1;
    #1;
    tick();
    checks++; if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd1) begin errors++; $display("FAIL err_cnt_zero got valid %b sel %0d exp 1 1", aw_valid_o, aw_sel_o); end
    rst_i = 1'b1; req_aw_valid_i = '0;
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL err_clear got err %b idle %b exp 0 1", err_o, idle_o); end
    $display("txn error flag cleared by reset");
  endtask

  task automatic test_stall();
    logic [31:0] exp_stall;
`ifdef WR_SCHED_PERF_CNT_EN
    exp_stall = 32'd7;
`else
    exp_stall = 32'd0;
`endif
    do_reset();
    req_aw_valid_i = 3'b001; aw_ready_i = 1'b0;
    #1;
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++; if (aw_valid_o !== 1'b1 || aw_sel_o !== 2'd0 || req_aw_ready_o !== 3'b000) begin errors++; $display("FAIL stall_hold %0d got valid %b sel %0d ready %b exp 1 0 000", i, aw_valid_o, aw_sel_o, req_aw_ready_o); end
      tick();
    end
    checks++; if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt_o, exp_stall); end
    $display("txn stall count %0d", stall_cnt_o);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (aw_valid_o !== 1'b0 || idle_o !== 1'b1 || stall_cnt_o !== 32'd0) begin errors++; $display("FAIL stall_reset got valid %b idle %b stall %0d exp 0 1 0", aw_valid_o, idle_o, stall_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_rr_wrap();
    test_max_outstanding();
    test_w_order();
    test_err();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
